// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit-serial transmit path: FSM states,
// default word width and the counter-width helper.
package bit_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int NN_WORD_W = 8;

    // Bit counter width: $clog2(width), but never narrower than one bit
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_serializer_piso_shift_reg.sv
// Parallel-in/serial-out shift register; load has priority over shift.
// The serial tap sits at the end the register shifts toward.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             serial
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= LSB_FIRST ? (sr >> 1) : (sr << 1);
        end
    end

    assign serial = LSB_FIRST ? sr[0] : sr[WIDTH-1];

endmodule

// File: rtl/bit_serializer.sv
// Word-to-bit-stream transmitter: valid/ready word in, valid/ready bit out
// with a last-bit marker. Back-to-back words stream without a bubble.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = NN_WORD_W,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            serial;
    logic            accept;
    logic            xfer;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_valid = (state == ST_SHIFT);
        out_last  = out_valid && (cnt == CW'(WIDTH - 1));
        xfer      = out_valid && out_ready;
        // in_ready is gated by clr so it drops immediately on reset assertion
        in_ready  = clr && ((state == ST_IDLE) || (xfer && out_last));
        accept    = in_valid && in_ready;
        out_bit   = out_valid && serial;
        busy      = out_valid;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                if (xfer) begin
                    if (out_last) begin
                        state_nxt = accept ? ST_SHIFT : ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_sr (
        .clk    (clk),
        .clr    (clr),
        .load   (accept),
        .shift  (xfer),
        .din    (in_data),
        .serial (serial)
    );

endmodule
